// File: rtl/dsi_packet_assembler.sv
// DSI packet sequencer: header {ECC,WC,DI}, masked payload beats with running CRC-16, 2-byte CRC footer.
// Header and payload beats appear 1 cycle after accept; a single output register holds its beat stable while stalled.
module dsi_packet_assembler #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter logic [15:0] MAX_WC   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_long,
  input  logic [7:0]  i_cmd_data_id,
  input  logic [15:0] i_cmd_word_count,
  input  logic        i_pld_valid,
  output logic        o_pld_ready,
  input  logic [31:0] i_pld_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic [1:0]  o_out_bytes,
  output logic        o_out_last,
  output logic        o_busy,
  output logic        o_pkt_done
);

  typedef enum logic [1:0] {S_IDLE, S_PLD, S_FTR, S_WAIT_END} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_crc, w_crc_nxt, w_crc_pld;
  logic [15:0] r_rem, w_rem_nxt;
  logic        r_out_valid, r_out_last;
  logic [31:0] r_out_data;
  logic [1:0]  r_out_bytes;
  logic        w_out_ld, w_last_hs, w_over;
  logic        w_ld, w_ld_last;
  logic [31:0] w_ld_data, w_pld_msk, w_hdr;
  logic [1:0]  w_ld_bytes;
  logic [15:0] w_wc;
  logic [2:0]  w_n;

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    ecc_calc[0] = ^(d & 24'hF12CB7);
    ecc_calc[1] = ^(d & 24'hF2555B);
    ecc_calc[2] = ^(d & 24'h749A6D);
    ecc_calc[3] = ^(d & 24'hB8E38E);
    ecc_calc[4] = ^(d & 24'hDF03F0);
    ecc_calc[5] = ^(d & 24'hEFFC00);
  endfunction

  // Byte-wise reflected CCITT update (polynomial 0x8408), LSB of each byte first on the wire.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = d ^ c[7:0];
    x = x ^ {x[3:0], 4'h0};
    crc_byte = {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'h00, x, 3'b000};
  endfunction

  assign w_out_ld  = !r_out_valid || i_out_ready;
  assign w_last_hs = r_out_valid && i_out_ready && r_out_last;
  assign w_over    = 17'(i_cmd_word_count) > 17'(MAX_WC);
  assign w_wc      = (i_cmd_long && w_over) ? MAX_WC : i_cmd_word_count;
  assign w_hdr     = {2'b00, ecc_calc({w_wc, i_cmd_data_id}), w_wc, i_cmd_data_id};
  assign w_n       = (r_rem >= 16'd4) ? 3'd4 : r_rem[2:0];

  always_comb begin
    w_pld_msk = '0;
    w_crc_pld = r_crc;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_n) begin
        w_pld_msk[8*i +: 8] = i_pld_data[8*i +: 8];
        w_crc_pld = crc_byte(w_crc_pld, i_pld_data[8*i +: 8]);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_pld_ready = 1'b0;
    w_ld        = 1'b0;
    w_ld_data   = '0;
    w_ld_bytes  = '0;
    w_ld_last   = 1'b0;
    w_crc_nxt   = r_crc;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: o_cmd_ready = 1'b1;
      S_PLD: begin
        o_pld_ready = w_out_ld;
        if (i_pld_valid && w_out_ld) begin
          w_ld       = 1'b1;
          w_ld_data  = w_pld_msk;
          w_ld_bytes = 2'(w_n - 3'd1);
          w_crc_nxt  = w_crc_pld;
          w_rem_nxt  = r_rem - {13'h0000, w_n};
          if (r_rem == {13'h0000, w_n}) w_state_nxt = S_FTR;
        end
      end
      S_FTR: begin
        if (w_out_ld) begin
          w_ld        = 1'b1;
          w_ld_data   = {16'h0000, r_crc};
          w_ld_bytes  = 2'd1;
          w_ld_last   = 1'b1;
          w_state_nxt = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        o_cmd_ready = i_out_ready;
        if (w_last_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The header is loaded on the accept edge itself, so a command taken
    // alongside the previous footer handshake follows it with no idle beat.
    if (o_cmd_ready && i_cmd_valid) begin
      w_ld        = 1'b1;
      w_ld_data   = w_hdr;
      w_ld_bytes  = 2'd3;
      w_ld_last   = !i_cmd_long;
      w_crc_nxt   = CRC_INIT;
      w_rem_nxt   = w_wc;
      if (!i_cmd_long)       w_state_nxt = S_WAIT_END;
      else if (w_wc == '0)   w_state_nxt = S_FTR;
      else                   w_state_nxt = S_PLD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc       <= CRC_INIT;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_crc <= w_crc_nxt;
      r_rem <= w_rem_nxt;
      if (w_ld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ld_data;
        r_out_bytes <= w_ld_bytes;
        r_out_last  <= w_ld_last;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_bytes = r_out_bytes;
  assign o_out_last  = r_out_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_pkt_done  = w_last_hs;

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: table of single packets plus stall, back-to-back and mid-packet reset sequences.
module tb_dsi_packet_assembler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_long;
  logic [7:0]  i_cmd_data_id;
  logic [15:0] i_cmd_word_count;
  logic        i_pld_valid, o_pld_ready;
  logic [31:0] i_pld_data;
  logic        o_out_valid, i_out_ready;
  logic [31:0] o_out_data;
  logic [1:0]  o_out_bytes;
  logic        o_out_last, o_busy, o_pkt_done;

  always #5 clk = ~clk;

  dsi_packet_assembler dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_long(i_cmd_long),
    .i_cmd_data_id(i_cmd_data_id), .i_cmd_word_count(i_cmd_word_count),
    .i_pld_valid(i_pld_valid), .o_pld_ready(o_pld_ready), .i_pld_data(i_pld_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_bytes(o_out_bytes), .o_out_last(o_out_last), .o_busy(o_busy), .o_pkt_done(o_pkt_done)
  );

  typedef struct {
    logic             lng;
    logic [7:0]       di;
    logic [15:0]      wc;
    bit               stall;
    int               nw;
    logic [3:0][31:0] w;
    int               nb;
    logic [5:0][31:0] ed;
    logic [5:0][1:0]  eb;
  } vec_t;

  vec_t tv[7];

  int checks = 0;
  int failures = 0;

  logic        c_long[4];
  logic [7:0]  c_di[4];
  logic [15:0] c_wc[4];
  int          ncmd;
  logic [31:0] pw[16];
  int          npw;

  logic [31:0] cap_d[16];
  logic [1:0]  cap_b[16];
  logic        cap_l[16];
  int          cap_cyc[16], cap_vis[16];
  int          acc_cyc[4], done_cyc[4], pacc_cyc[16];
  int          nbeat, pidx, nd, pd_bad;
  bit          unstable, timed_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic nv(input int v, input logic lng, input logic [7:0] di, input logic [15:0] wc, input bit st);
    tv[v].lng = lng; tv[v].di = di; tv[v].wc = wc; tv[v].stall = st;
    tv[v].nw = 0; tv[v].nb = 0; tv[v].w = '0; tv[v].ed = '0; tv[v].eb = '0;
  endtask

  task automatic aw(input int v, input logic [31:0] w);
    tv[v].w[tv[v].nw] = w;
    tv[v].nw++;
  endtask

  task automatic ab(input int v, input logic [31:0] d, input logic [1:0] b);
    tv[v].ed[tv[v].nb] = d;
    tv[v].eb[tv[v].nb] = b;
    tv[v].nb++;
  endtask

  task automatic load_vec(input int v);
    ncmd = 1;
    c_long[0] = tv[v].lng; c_di[0] = tv[v].di; c_wc[0] = tv[v].wc;
    for (int i = 0; i < tv[v].nw; i++) pw[i] = tv[v].w[i];
    pw[tv[v].nw] = 32'hDEADBEEF;
    npw = tv[v].nw + 1;
  endtask

  // One cycle per iteration: inputs set at negedge, handshakes judged 1 time unit later.
  task automatic run_seq(input bit stall, input int abort_at);
    int ci = 0;
    int stall_cnt = 0;
    int vis = 0;
    bit seen = 1'b0;
    logic [31:0] hd = '0;
    logic [1:0]  hb = '0;
    logic        hl = 1'b0;
    pidx = 0; nd = 0; nbeat = 0; pd_bad = 0; unstable = 1'b0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (stall && o_out_valid && stall_cnt < 5) begin
        i_out_ready = 1'b0;
        if (stall_cnt == 0) begin hd = o_out_data; hb = o_out_bytes; hl = o_out_last; end
        else if (o_out_data !== hd || o_out_bytes !== hb || o_out_last !== hl) unstable = 1'b1;
        stall_cnt++;
      end else begin
        i_out_ready = 1'b1;
        if (stall && stall_cnt > 0 && (o_out_data !== hd || o_out_bytes !== hb || o_out_last !== hl))
          unstable = 1'b1;
      end
      i_cmd_valid = (ci < ncmd);
      if (ci < ncmd) begin
        i_cmd_long = c_long[ci]; i_cmd_data_id = c_di[ci]; i_cmd_word_count = c_wc[ci];
      end
      i_pld_valid = (pidx < npw);
      i_pld_data  = (pidx < npw) ? pw[pidx] : 32'h0;
      #1;
      if (o_out_valid && !seen) begin seen = 1'b1; vis = cyc; end
      if (o_out_valid && i_out_ready) begin
        if (nbeat < 16) begin
          cap_d[nbeat] = o_out_data; cap_b[nbeat] = o_out_bytes; cap_l[nbeat] = o_out_last;
          cap_cyc[nbeat] = cyc; cap_vis[nbeat] = vis;
        end
        nbeat++; seen = 1'b0; stall_cnt = 0;
        if (o_out_last) begin
          if (!o_pkt_done) pd_bad++;
          if (nd < 4) done_cyc[nd] = cyc;
          nd++;
        end else if (o_pkt_done) pd_bad++;
      end else if (o_pkt_done) pd_bad++;
      if (i_cmd_valid && o_cmd_ready) begin acc_cyc[ci] = cyc; ci++; end
      if (i_pld_valid && o_pld_ready) begin pacc_cyc[pidx] = cyc; pidx++; end
      if (nd >= ncmd || (abort_at > 0 && pidx == abort_at)) begin timed_out = 1'b0; break; end
    end
    chk("seq_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    logic [15:0] c;
    reset_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_long = 1'b0; i_cmd_data_id = '0; i_cmd_word_count = '0;
    i_pld_valid = 1'b0; i_pld_data = '0; i_out_ready = 1'b0;

    nv(0, 1'b0, 8'h01, 16'h0000, 1'b0); ab(0, 32'h07000001, 2'd3);
    nv(1, 1'b0, 8'h05, 16'h0100, 1'b0); ab(1, 32'h3B010005, 2'd3);
    nv(2, 1'b1, 8'h29, 16'd0, 1'b0);    ab(2, 32'h1C000029, 2'd3); ab(2, 32'h0000FFFF, 2'd1);
    nv(3, 1'b1, 8'h29, 16'd6, 1'b0);
    aw(3, 32'h04030201); aw(3, 32'hAAAA0605);
    c = 16'hFFFF;
    for (int k = 1; k <= 6; k++) c = crc_upd(c, 8'(k));
    ab(3, 32'h23000629, 2'd3); ab(3, 32'h04030201, 2'd3); ab(3, 32'h00000605, 2'd1); ab(3, {16'h0, c}, 2'd1);
    for (int v = 4; v <= 5; v++) begin
      nv(v, 1'b1, 8'h29, 16'd9, v == 5);
      aw(v, 32'h34333231); aw(v, 32'h38373635); aw(v, 32'hBBBBBB39);
      ab(v, 32'h23000929, 2'd3); ab(v, 32'h34333231, 2'd3); ab(v, 32'h38373635, 2'd3);
      ab(v, 32'h00000039, 2'd0); ab(v, 32'h00006F91, 2'd1);
    end
    nv(6, 1'b1, 8'h29, 16'd4, 1'b0);
    aw(6, 32'h44332211);
    c = crc_upd(crc_upd(crc_upd(crc_upd(16'hFFFF, 8'h11), 8'h22), 8'h33), 8'h44);
    ab(6, 32'h3F000429, 2'd3); ab(6, 32'h44332211, 2'd3); ab(6, {16'h0, c}, 2'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pld_ready", 32'(o_pld_ready), 32'd0);
    chk("rst_pkt_done", 32'(o_pkt_done), 32'd0);
    chk("rst_out_data", o_out_data, 32'd0);
    chk("rst_out_bytes_last", {29'd0, o_out_bytes, o_out_last}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load_vec(v);
      run_seq(tv[v].stall, 0);
      chk($sformatf("v%0d_nbeats", v), nbeat, tv[v].nb);
      for (int i = 0; i < tv[v].nb && i < 16; i++) begin
        chk($sformatf("v%0d_b%0d_data", v, i), cap_d[i], tv[v].ed[i]);
        chk($sformatf("v%0d_b%0d_bytes", v, i), 32'(cap_b[i]), 32'(tv[v].eb[i]));
        chk($sformatf("v%0d_b%0d_last", v, i), 32'(cap_l[i]), 32'(i == tv[v].nb - 1));
      end
      chk($sformatf("v%0d_words_consumed", v), pidx, tv[v].nw);
      chk($sformatf("v%0d_pkt_done", v), pd_bad, 0);
      chk($sformatf("v%0d_hdr_latency", v), cap_vis[0] - acc_cyc[0], 1);
      if (tv[v].stall) chk($sformatf("v%0d_stall_stable", v), 32'(unstable), 32'd0);
      else if (tv[v].nw > 0) chk($sformatf("v%0d_pld_latency", v), cap_vis[1] - pacc_cyc[0], 1);
    end

    // Back-to-back: long WC=6 then short, second command held valid throughout.
    ncmd = 2;
    c_long[0] = 1'b1; c_di[0] = 8'h29; c_wc[0] = 16'd6;
    c_long[1] = 1'b0; c_di[1] = 8'h01; c_wc[1] = 16'h0000;
    pw[0] = 32'h04030201; pw[1] = 32'hAAAA0605; pw[2] = 32'hDEADBEEF; npw = 3;
    run_seq(1'b0, 0);
    chk("b2b_nbeats", nbeat, 5);
    chk("b2b_accept_at_done", acc_cyc[1], done_cyc[0]);
    chk("b2b_no_bubble", cap_vis[4], cap_cyc[3] + 1);
    chk("b2b_hdr2", cap_d[4], 32'h07000001);
    chk("b2b_footer1", cap_d[3], tv[3].ed[3]);
    chk("b2b_words", pidx, 2);

    // Reset after 2 of 4 payload words of a WC=16 packet.
    ncmd = 1;
    c_long[0] = 1'b1; c_di[0] = 8'h29; c_wc[0] = 16'd16;
    for (int i = 0; i < 4; i++) pw[i] = 32'h10101010 * (i + 1);
    npw = 4;
    run_seq(1'b0, 2);
    chk("rstmid_words", pidx, 2);
    @(posedge clk);
    #1;
    chk("rstmid_valid_before", 32'(o_out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(o_out_valid), 32'd0);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_pld_ready", 32'(o_pld_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    load_vec(6);
    run_seq(1'b0, 0);
    chk("rstnew_nbeats", nbeat, 3);
    chk("rstnew_hdr", cap_d[0], 32'h3F000429);
    chk("rstnew_pld", cap_d[1], 32'h44332211);
    chk("rstnew_footer", cap_d[2], tv[6].ed[2]);
    chk("rstnew_words", pidx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
